// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bundle between three requesters, the port arbiter and the SDRAM controller slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [3*ADDR_W-1:0] req_address;
  logic [2:0]          req_read;
  logic [2:0]          req_write;
  logic [3*DATA_W-1:0] req_writedata;
  logic [3*BE_W-1:0]   req_byteenable;
  logic [2:0]          req_waitrequest;
  logic [DATA_W-1:0]   req_readdata;
  logic [2:0]          req_readdatavalid;

  logic [ADDR_W-1:0]   s_address;
  logic                s_read;
  logic                s_write;
  logic [DATA_W-1:0]   s_writedata;
  logic [BE_W-1:0]     s_byteenable;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid;

  logic                err;

  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_byteenable,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output s_address, s_read, s_write, s_writedata, s_byteenable,
    input  s_waitrequest, s_readdata, s_readdatavalid,
    output err
  );

  modport master (
    output req_address, req_read, req_write, req_writedata, req_byteenable,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
    output s_waitrequest, s_readdata, s_readdatavalid,
    input  err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller slave among three single-word requesters,
// with a tag FIFO steering pipelined read returns back to the issuing port in order.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  sdram_port_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (TAG_DEPTH > 2) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [1:0]        grant, grant_nxt;
  logic [1:0]        last, last_nxt;
  logic [1:0]        tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              err;

  logic [2:0]        eligible;
  logic              found;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [BE_W-1:0]   g_be;
  logic              g_read, g_write;
  logic              busy, accept, push, pop, conflict, orphan;
  logic [1:0]        head;

  // A read is only eligible while a tag slot is free; writes never need one.
  assign eligible = bus.req_write | (bus.req_read & {3{count != FULL}});

  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((32'(last) + 32'(k)) % 3);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    g_addr  = bus.req_address[0 +: ADDR_W];
    g_wdata = bus.req_writedata[0 +: DATA_W];
    g_be    = bus.req_byteenable[0 +: BE_W];
    g_read  = bus.req_read[0];
    g_write = bus.req_write[0];
    case (grant)
      2'd1: begin
        g_addr  = bus.req_address[ADDR_W +: ADDR_W];
        g_wdata = bus.req_writedata[DATA_W +: DATA_W];
        g_be    = bus.req_byteenable[BE_W +: BE_W];
        g_read  = bus.req_read[1];
        g_write = bus.req_write[1];
      end
      2'd2: begin
        g_addr  = bus.req_address[2*ADDR_W +: ADDR_W];
        g_wdata = bus.req_writedata[2*DATA_W +: DATA_W];
        g_be    = bus.req_byteenable[2*BE_W +: BE_W];
        g_read  = bus.req_read[2];
        g_write = bus.req_write[2];
      end
      default: ;
    endcase
  end

  assign busy     = (state == BUSY);
  assign accept   = busy && !bus.s_waitrequest;
  // Write wins when a port raises both commands; the conflict is flagged.
  assign push     = accept && g_read && !g_write;
  assign pop      = bus.s_readdatavalid && (count != '0);
  assign conflict = busy && g_read && g_write;
  assign orphan   = bus.s_readdatavalid && (count == '0);
  assign head     = tag_mem[rd_ptr];

  assign bus.s_address    = g_addr;
  assign bus.s_writedata  = g_wdata;
  assign bus.s_byteenable = g_be;
  assign bus.s_read       = busy && g_read && !g_write;
  assign bus.s_write      = busy && g_write;
  assign bus.req_readdata = bus.s_readdata;
  assign bus.err          = err;

  always_comb begin
    bus.req_waitrequest   = 3'b111;
    bus.req_readdatavalid = 3'b000;
    if (accept) begin
      case (grant)
        2'd1:    bus.req_waitrequest = 3'b101;
        2'd2:    bus.req_waitrequest = 3'b011;
        default: bus.req_waitrequest = 3'b110;
      endcase
    end
    if (pop) begin
      case (head)
        2'd1:    bus.req_readdatavalid = 3'b010;
        2'd2:    bus.req_readdatavalid = 3'b100;
        default: bus.req_readdatavalid = 3'b001;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = winner;
          last_nxt  = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state  <= IDLE;
      grant  <= 2'd0;
      last   <= 2'd2;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (conflict || orphan) err <= 1'b1;
    end
  end

  // Tag storage holds data only, so it is left out of reset.
  always_ff @(posedge clk_clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reset, single read, round robin, stall hold,
// tag ordering/full, simultaneous push/pop, and error handling.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(25), .DATA_W(32)) bus ();

  sdram_port_arbiter #(.ADDR_W(25), .DATA_W(32), .TAG_DEPTH(8)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [24:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_read[p]              = rd;
    bus.req_write[p]             = wr;
    bus.req_address[p*25 +: 25]  = a;
    bus.req_writedata[p*32 +: 32] = d;
    bus.req_byteenable[p*4 +: 4] = be;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_waitrequest   = 1'b0;
    bus.s_readdatavalid = 1'b0;
    bus.s_readdata      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_port(0, 0, 0, 25'h0ABCDE, 32'h11111111, 4'hF);
    set_port(1, 0, 0, 25'h1BCDEF, 32'h22222222, 4'h3);
    set_port(2, 0, 0, 25'h0C0FFE, 32'h33333333, 4'hC);
    do_reset();
    #1;
    total++;
    if (bus.req_waitrequest !== 3'b111 || bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL reset_req wait=%b rdv=%b expected 111/000", bus.req_waitrequest, bus.req_readdatavalid);
    end
    total++;
    if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd rd=%b wr=%b err=%b expected 0/0/0", bus.s_read, bus.s_write, bus.err);
    end
    total++;
    if (bus.s_address !== 25'h0ABCDE || bus.s_writedata !== 32'h11111111 || bus.s_byteenable !== 4'hF) begin
      bad++;
      $display("FAIL reset_mux addr=%h wd=%h be=%h expected 0abcde/11111111/f",
               bus.s_address, bus.s_writedata, bus.s_byteenable);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_port(1, 1, 0, 25'h100, 32'h0, 4'hF);
    #1;
    total++;
    if (bus.req_waitrequest !== 3'b111 || bus.s_read !== 1'b0) begin
      bad++;
      $display("FAIL single_cycle0 wait=%b s_read=%b expected 111/0", bus.req_waitrequest, bus.s_read);
    end
    tick();
    #1;
    total++;
    if (bus.req_waitrequest !== 3'b101 || bus.s_read !== 1'b1 || bus.s_address !== 25'h100) begin
      bad++;
      $display("FAIL single_accept wait=%b s_read=%b addr=%h expected 101/1/100",
               bus.req_waitrequest, bus.s_read, bus.s_address);
    end
    tick();
    set_port(1, 0, 0, 25'h100, 32'h0, 4'hF);
    tick();
    tick();
    bus.s_readdatavalid = 1'b1;
    bus.s_readdata      = 32'hDEADBEEF;
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b010 || bus.req_readdata !== 32'hDEADBEEF || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL single_return rdv=%b data=%h err=%b expected 010/deadbeef/0",
               bus.req_readdatavalid, bus.req_readdata, bus.err);
    end
    tick();
    bus.s_readdatavalid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_wr;
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 0, 1, 25'(p + 1), 32'(p), 4'hF);
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_wr = (c % 2 == 0) ? 3'b111 : ~(3'b001 << (((c - 1) / 2) % 3));
      total++;
      if (bus.req_waitrequest !== exp_wr) begin
        bad++;
        $display("FAIL rr_cycle%0d wait=%b expected %b", c, bus.req_waitrequest, exp_wr);
      end
      tick();
    end
    for (int p = 0; p < 3; p++) set_port(p, 0, 0, 25'h0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_stall_hold();
    logic [62:0] exp_bus;
    do_reset();
    set_port(2, 0, 1, 25'h1ABCDE, 32'hA5A5A5A5, 4'b0011);
    bus.s_waitrequest = 1'b1;
    tick();
    exp_bus = {1'b1, 25'h1ABCDE, 32'hA5A5A5A5, 4'b0011, 1'b0};
    for (int b = 1; b <= 6; b++) begin
      bus.s_waitrequest = (b <= 5);
      #1;
      total++;
      if ({bus.s_write, bus.s_address, bus.s_writedata, bus.s_byteenable, bus.s_read} !== exp_bus) begin
        bad++;
        $display("FAIL stall_bus%0d got=%h expected %h", b,
                 {bus.s_write, bus.s_address, bus.s_writedata, bus.s_byteenable, bus.s_read}, exp_bus);
      end
      total++;
      if (bus.req_waitrequest !== ((b <= 5) ? 3'b111 : 3'b011)) begin
        bad++;
        $display("FAIL stall_wait%0d wait=%b expected %b", b, bus.req_waitrequest,
                 (b <= 5) ? 3'b111 : 3'b011);
      end
      tick();
    end
    set_port(2, 0, 0, 25'h0, 32'h0, 4'h0);
    #1;
    total++;
    if (bus.s_write !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle s_write=%b expected 0", bus.s_write);
    end
  endtask

  task automatic test_tag_full();
    logic [2:0] exp_v;
    logic       seen;
    do_reset();
    set_port(0, 1, 0, 25'h200, 32'h0, 4'hF);
    set_port(1, 1, 0, 25'h300, 32'h0, 4'hF);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c % 2 == 1) begin
        exp_v = ~(3'b001 << (((c - 1) / 2) % 2));
        total++;
        if (bus.req_waitrequest !== exp_v) begin
          bad++;
          $display("FAIL tag_issue%0d wait=%b expected %b", c, bus.req_waitrequest, exp_v);
        end
      end
      tick();
    end
    set_port(1, 0, 0, 25'h300, 32'h0, 4'hF);
    set_port(2, 0, 1, 25'h400, 32'hCAFE0002, 4'hF);
    tick();
    #1;
    total++;
    if (bus.req_waitrequest !== 3'b011 || bus.s_write !== 1'b1 || bus.s_address !== 25'h400) begin
      bad++;
      $display("FAIL tag_full_write wait=%b s_write=%b addr=%h expected 011/1/400",
               bus.req_waitrequest, bus.s_write, bus.s_address);
    end
    tick();
    set_port(2, 0, 0, 25'h0, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (bus.req_waitrequest !== 3'b111 || bus.s_read !== 1'b0) begin
        bad++;
        $display("FAIL tag_full_stall%0d wait=%b s_read=%b expected 111/0", c, bus.req_waitrequest, bus.s_read);
      end
      tick();
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.s_readdatavalid = 1'b1;
      bus.s_readdata      = 32'h1000 + 32'(k);
      #1;
      exp_v = (k % 2 == 0) ? 3'b001 : 3'b010;
      total++;
      if (bus.req_readdatavalid !== exp_v || bus.req_readdata !== 32'h1000 + 32'(k)) begin
        bad++;
        $display("FAIL tag_return%0d rdv=%b data=%h expected %b/%h", k, bus.req_readdatavalid,
                 bus.req_readdata, exp_v, 32'h1000 + 32'(k));
      end
      if (bus.req_waitrequest[0] === 1'b0) seen = 1'b1;
      tick();
      if (seen) bus.req_read[0] = 1'b0;
    end
    bus.s_readdatavalid = 1'b0;
    bus.req_read[0]     = 1'b0;
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL tag_ninth_granted seen=%b expected 1", seen);
    end
    bus.s_readdatavalid = 1'b1;
    bus.s_readdata      = 32'h9999;
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b001) begin
      bad++;
      $display("FAIL tag_ninth_return rdv=%b expected 001", bus.req_readdatavalid);
    end
    tick();
    bus.s_readdatavalid = 1'b0;
    #1;
    total++;
    if (dut.count !== 4'd0) begin
      bad++;
      $display("FAIL tag_drained count=%0d expected 0", dut.count);
    end
  endtask

  task automatic test_push_pop();
    logic [2:0] exp_d [3];
    exp_d[0] = 3'b010; exp_d[1] = 3'b010; exp_d[2] = 3'b100;
    do_reset();
    set_port(1, 1, 0, 25'h010, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) tick();
    set_port(1, 0, 0, 25'h010, 32'h0, 4'hF);
    #1;
    total++;
    if (dut.count !== 4'd3) begin
      bad++;
      $display("FAIL pp_count_before count=%0d expected 3", dut.count);
    end
    set_port(2, 1, 0, 25'h020, 32'h0, 4'hF);
    tick();
    bus.s_readdatavalid = 1'b1;
    bus.s_readdata      = 32'h33;
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b010 || bus.req_waitrequest !== 3'b011) begin
      bad++;
      $display("FAIL pp_same_cycle rdv=%b wait=%b expected 010/011", bus.req_readdatavalid, bus.req_waitrequest);
    end
    tick();
    bus.s_readdatavalid = 1'b0;
    set_port(2, 0, 0, 25'h020, 32'h0, 4'hF);
    #1;
    total++;
    if (dut.count !== 4'd3) begin
      bad++;
      $display("FAIL pp_count_after count=%0d expected 3", dut.count);
    end
    for (int k = 0; k < 3; k++) begin
      bus.s_readdatavalid = 1'b1;
      #1;
      total++;
      if (bus.req_readdatavalid !== exp_d[k]) begin
        bad++;
        $display("FAIL pp_drain%0d rdv=%b expected %b", k, bus.req_readdatavalid, exp_d[k]);
      end
      tick();
    end
    bus.s_readdatavalid = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    bus.s_readdatavalid = 1'b1;
    bus.s_readdata      = 32'hBAD;
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL err_orphan_strobe rdv=%b expected 000", bus.req_readdatavalid);
    end
    tick();
    bus.s_readdatavalid = 1'b0;
    #1;
    total++;
    if (bus.err !== 1'b1) begin
      bad++;
      $display("FAIL err_orphan_flag err=%b expected 1", bus.err);
    end
    set_port(0, 1, 1, 25'h55, 32'h1234, 4'hF);
    tick();
    #1;
    total++;
    if (bus.s_write !== 1'b1 || bus.s_read !== 1'b0 || bus.s_address !== 25'h55 ||
        bus.s_writedata !== 32'h1234 || bus.req_waitrequest !== 3'b110) begin
      bad++;
      $display("FAIL err_rw_conflict wr=%b rd=%b addr=%h wd=%h wait=%b expected 1/0/55/1234/110",
               bus.s_write, bus.s_read, bus.s_address, bus.s_writedata, bus.req_waitrequest);
    end
    tick();
    set_port(0, 0, 0, 25'h0, 32'h0, 4'hF);
    tick();
    tick();
    #1;
    total++;
    if (bus.err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky err=%b expected 1", bus.err);
    end
    set_port(1, 1, 0, 25'h77, 32'h0, 4'hF);
    bus.s_waitrequest = 1'b1;
    tick();
    rst = 1'b1;
    set_port(1, 0, 0, 25'h77, 32'h0, 4'hF);
    tick();
    rst = 1'b0;
    bus.s_waitrequest = 1'b0;
    #1;
    total++;
    if (bus.err !== 1'b0 || bus.req_waitrequest !== 3'b111 || bus.s_read !== 1'b0 || dut.count !== 4'd0) begin
      bad++;
      $display("FAIL err_reset_clear err=%b wait=%b s_read=%b count=%0d expected 0/111/0/0",
               bus.err, bus.req_waitrequest, bus.s_read, dut.count);
    end
    bus.s_readdatavalid = 1'b1;
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL err_inflight_strobe rdv=%b expected 000", bus.req_readdatavalid);
    end
    tick();
    bus.s_readdatavalid = 1'b0;
    #1;
    total++;
    if (bus.err !== 1'b1) begin
      bad++;
      $display("FAIL err_inflight_flag err=%b expected 1", bus.err);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_address    = '0;
    bus.req_writedata  = '0;
    bus.req_byteenable = '0;
    bus.s_waitrequest  = 1'b0;
    bus.s_readdata     = '0;
    bus.s_readdatavalid = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall_hold();
    test_tag_full();
    test_push_pop();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares the single SDRAM controller Avalon-MM slave among three single-word Avalon-MM requesters inside the DNN accelerator system:
- port 0: VGA frame reader
- port 1: DNN weight/activation reader
- port 2: DNN result writer

It registers one grant per transaction and holds every slave-side signal stable while the controller stalls. A tag FIFO records which port issued each accepted read, so pipelined read data returns to the correct requester in issue order.

## Interface
- ADDR_W, default 25: word address width toward the SDRAM controller.
- DATA_W, default 32: data width; byteenable width is DATA_W/8.
- TAG_DEPTH, default 8: maximum outstanding reads; must be a power of two ≥ 2.
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- req_address  in  3*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_read, req_write  in  3  per-port command bits.
- req_writedata  in  3*DATA_W  per-port write data.
- req_byteenable  in  3*DATA_W/8  per-port byte enables.
- req_waitrequest  out  3  per-port stall; low only in the accept cycle.
- req_readdata  out  DATA_W  s_readdata broadcast to all ports.
- req_readdatavalid  out  3  one-hot read-return strobe.
- s_address  out  ADDR_W  mux of the granted port's address.
- s_read, s_write  out  1  granted command, qualified by BUSY.
- s_writedata  out  DATA_W  mux of the granted port's write data.
- s_byteenable  out  DATA_W/8  mux of the granted port's byte enables.
- s_waitrequest  in  1  controller stall.
- s_readdata  in  DATA_W  controller read data.
- s_readdatavalid  in  1  controller read-return strobe.
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant register (2 bits) drives the slave mux.
- Eligibility in IDLE:
  - Port i is eligible if req_write[i] is set.
  - Port i is also eligible if req_read[i] is set and tag count < TAG_DEPTH.
- Arbitration in IDLE: among eligible ports, the winner is the first found scanning from last+1 upward, modulo 3.
  - On a winner: grant ← winner, last ← winner, go to BUSY.
  - With no eligible port, stay in IDLE.
- In BUSY:
  - s_read/s_write/s_address/s_writedata/s_byteenable are a pure mux of the granted port.
  - A requester must hold its signals while its waitrequest is high, so slave outputs stay stable across stalls.
- Accept condition: BUSY and s_waitrequest = 0.
  - req_waitrequest[grant] = 0 that cycle; every other bit is 1.
  - A read pushes the grant into the tag FIFO.
  - The block returns to IDLE.
- Read return: s_readdatavalid = 1 pops the FIFO head.
  - req_readdatavalid[head] = 1 in the same cycle.
  - req_readdata = s_readdata in the same cycle.
- Push and pop in the same cycle: count is unchanged and both operations succeed.
- s_readdatavalid with the FIFO empty: no strobe to any port; err ← 1.
- req_read and req_write both set on the granted port: the transaction is a write (s_read = 0) and err ← 1.
- Reset mid-transaction:
  - State, FIFO, and grant are all cleared.
  - Controller responses still in flight after reset hit an empty FIFO; they set err and are discarded.

## Timing
- Reset values:
  - state = IDLE, last = 2 (port 0 wins first), FIFO count = 0, err = 0.
  - s_read = s_write = 0.
  - req_waitrequest = 3'b111, req_readdatavalid = 0.
  - s_address, s_writedata, s_byteenable = the port 0 mux value.
- Request latency: a request first seen in IDLE at cycle n is granted at edge n+1.
  - With s_waitrequest low, it is accepted in cycle n+1.
  - req_waitrequest is therefore high for at least one cycle.
- Throughput: at most one accepted transaction per 2 cycles; there is a mandatory IDLE bubble between grants.
- Read data path: combinational from s_readdatavalid/s_readdata to req_*, adding 0 cycles of latency.
- The FIFO full check uses the count in the IDLE cycle. Count cannot rise again before that grant is accepted, so overflow is impossible.
- Fairness: any continuously asserted eligible request is accepted within 3 grants.

## Test plan
- Single read: port 1 reads addr 0x100; s_waitrequest low; controller returns 0xDEADBEEF 3 cycles after accept.
  - Required: req_waitrequest[1] low in cycle 1.
  - Required: req_readdatavalid = 3'b010 with data 0xDEADBEEF; err = 0.
- Round robin: all three ports hold writes continuously after reset.
  - Required: accept order 0, 1, 2, 0, 1, 2, exactly one accept every 2 cycles.
- Stall hold: port 2 writes 0xA5A5A5A5, byteenable 4'b0011; s_waitrequest high for 5 cycles.
  - Required: slave outputs are constant for all stall cycles.
  - Required: the accept lands on the 6th BUSY cycle; the other ports see waitrequest = 1 throughout.
- Tag ordering and full: TAG_DEPTH = 8; ports 0 and 1 issue 8 alternating reads with no returns.
  - Required: a 9th read stays stalled in IDLE, while a port 2 write is still granted.
  - After 8 returns, the strobes follow issue order 0, 1, 0, 1, …; then the 9th read is granted.
- Simultaneous push/pop: a read accept coincides with a return at count 3.
  - Required: count stays 3; the correct port is strobed.
- Errors: s_readdatavalid with an empty FIFO, then read+write together on port 0.
  - Required: no port strobed; err = 1 and stays 1; the write executes.
  - Required: reset_reset clears err and returns the block to IDLE.
